// File: rtl/store_unit.sv
// store_unit: memory-stage executor for SB/SH/SW stores with alignment check,
// lane replication and a single-outstanding req/ack transaction with ack timeout.
package store_unit_pkg;
    typedef logic [3:0] oper_t;
    localparam oper_t OP_NOP = 4'd0;
    localparam oper_t OP_SB  = 4'd1;
    localparam oper_t OP_SH  = 4'd2;
    localparam oper_t OP_SW  = 4'd3;
endpackage

module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  oper_t       in_op,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        done_valid,
    output logic [1:0]  done_fault,
    output logic [31:0] done_addr
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_nx;
    logic [31:0]     eaddr, eaddr_q, wdata_d, wdata_q;
    logic [3:0]      be_d, be_q;
    logic [1:0]      fault_q;
    logic [TO_W-1:0] cnt;
    logic            is_sb, is_sh, is_sw, is_store, misaligned, last;

    always_comb begin
        eaddr      = in_base + in_imm;
        is_sb      = in_op == OP_SB;
        is_sh      = in_op == OP_SH;
        is_sw      = in_op == OP_SW;
        is_store   = is_sb || is_sh || is_sw;
        misaligned = (is_sh && eaddr[0]) || (is_sw && eaddr[1:0] != 2'b00);
        be_d       = is_sb ? 4'b0001 << eaddr[1:0] : is_sh ? 4'b0011 << eaddr[1:0] : 4'b1111;
        wdata_d    = is_sb ? {4{in_data[7:0]}} : is_sh ? {2{in_data[15:0]}} : in_data;
        last       = cnt == TO_W'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !in_valid ? IDLE : (is_store && !misaligned) ? REQ : RESP;
            REQ:     state_nx = (mem_ack || last) ? RESP : REQ;
            default: state_nx = IDLE;
        endcase
    end

    // Transaction context is captured at accept; only the counter and timeout fault evolve in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eaddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            fault_q <= '0;
            cnt     <= '0;
        end else if (state == IDLE && in_valid) begin
            eaddr_q <= eaddr;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            fault_q <= misaligned ? 2'b01 : 2'b00;
            cnt     <= '0;
        end else if (state == REQ && !mem_ack) begin
            cnt     <= cnt + 1'b1;
            fault_q <= last ? 2'b10 : fault_q;
        end
    end

    always_comb begin
        in_ready   = state == IDLE;
        mem_req    = state == REQ;
        mem_addr   = mem_req ? {eaddr_q[31:2], 2'b00} : '0;
        mem_be     = mem_req ? be_q : '0;
        mem_wdata  = mem_req ? wdata_q : '0;
        done_valid = state == RESP;
        done_fault = done_valid ? fault_q : '0;
        done_addr  = done_valid ? eaddr_q : '0;
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed-vector bench for store_unit with TIMEOUT_CYCLES=4.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    oper_t       in_op = OP_NOP;
    logic [31:0] in_base = '0, in_imm = '0, in_data = '0;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata, done_addr;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        done_valid;
    logic [1:0]  done_fault;
    int          tests = 0, fails = 0;

    store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_base(in_base), .in_imm(in_imm), .in_data(in_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done_valid(done_valid), .done_fault(done_fault), .done_addr(done_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, lets it be accepted, and returns 1ns into cycle 1.
    task automatic start(input oper_t op, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] data);
        in_valid = 1'b1;
        in_op    = op;
        in_base  = base;
        in_imm   = imm;
        in_data  = data;
        step();
        in_valid = 1'b0;
        in_op    = OP_NOP;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done_valid), 32'd0);
        chk("rst_fault", 32'(done_fault), 32'd0);
        chk("rst_daddr", done_addr, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // 1: SW, immediate ack
        start(OP_SW, 32'h1000, 32'd4, 32'hDEADBEEF);
        mem_ack = 1'b1;
        chk("sw_req", 32'(mem_req), 32'd1);
        chk("sw_addr", mem_addr, 32'h1004);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_busy", 32'(in_ready), 32'd0);
        chk("sw_nodone1", 32'(done_valid), 32'd0);
        step();
        mem_ack = 1'b0;
        chk("sw_done", 32'(done_valid), 32'd1);
        chk("sw_fault", 32'(done_fault), 32'd0);
        chk("sw_daddr", done_addr, 32'h1004);
        chk("sw_req_off", 32'(mem_req), 32'd0);
        chk("sw_be_off", 32'(mem_be), 32'd0);
        step();
        chk("sw_pulse", 32'(done_valid), 32'd0);
        chk("sw_idle", 32'(in_ready), 32'd1);

        // 2: SB with negative immediate
        start(OP_SB, 32'h2003, 32'hFFFFFFFF, 32'h123456A5);
        mem_ack = 1'b1;
        chk("sb_addr", mem_addr, 32'h2000);
        chk("sb_be", 32'(mem_be), 32'b0100);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        step();
        mem_ack = 1'b0;
        chk("sb_done", 32'(done_valid), 32'd1);
        chk("sb_daddr", done_addr, 32'h2002);
        step();

        // SH aligned on upper half
        start(OP_SH, 32'h2000, 32'd2, 32'hCAFEBABE);
        mem_ack = 1'b1;
        chk("sh_be", 32'(mem_be), 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hBABEBABE);
        step();
        mem_ack = 1'b0;
        chk("sh_fault", 32'(done_fault), 32'd0);
        step();

        // 3: misaligned SH / SW
        start(OP_SH, 32'h3000, 32'd1, 32'h1111);
        chk("msh_req", 32'(mem_req), 32'd0);
        chk("msh_done", 32'(done_valid), 32'd1);
        chk("msh_fault", 32'(done_fault), 32'd1);
        chk("msh_daddr", done_addr, 32'h3001);
        step();
        chk("msh_pulse", 32'(done_valid), 32'd0);
        chk("msh_idle", 32'(in_ready), 32'd1);
        start(OP_SW, 32'h3000, 32'd2, 32'h2222);
        chk("msw_req", 32'(mem_req), 32'd0);
        chk("msw_done", 32'(done_valid), 32'd1);
        chk("msw_fault", 32'(done_fault), 32'd1);
        chk("msw_daddr", done_addr, 32'h3002);
        step();

        // 4: timeout with ack withheld
        start(OP_SW, 32'h100, 32'd0, 32'h0);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'd4);
        chk("to_done", 32'(done_valid), 32'd1);
        chk("to_fault", 32'(done_fault), 32'd2);
        step();
        // ack on the final cycle wins
        start(OP_SW, 32'h100, 32'd0, 32'h0);
        step();
        step();
        step();
        chk("to4_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to4_done", 32'(done_valid), 32'd1);
        chk("to4_fault", 32'(done_fault), 32'd0);
        step();

        // 5: reset during REQ
        start(OP_SW, 32'h500, 32'd0, 32'h77);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req", 32'(mem_req), 32'd0);
        chk("rr_ready", 32'(in_ready), 32'd1);
        chk("rr_done", 32'(done_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rr_done2", 32'(done_valid), 32'd0);
        start(OP_SW, 32'h600, 32'd8, 32'h55AA55AA);
        mem_ack = 1'b1;
        chk("rr_wdata", mem_wdata, 32'h55AA55AA);
        step();
        mem_ack = 1'b0;
        chk("rr_sw_done", 32'(done_valid), 32'd1);
        chk("rr_sw_daddr", done_addr, 32'h608);
        step();

        // 6: address wrap and no-op
        start(OP_SW, 32'hFFFFFFFC, 32'd8, 32'h0BADF00D);
        mem_ack = 1'b1;
        chk("wrap_addr", mem_addr, 32'h4);
        step();
        mem_ack = 1'b0;
        chk("wrap_daddr", done_addr, 32'h4);
        step();
        mem_ack = 1'b1;
        start(OP_NOP, 32'h10, 32'h20, 32'h0);
        chk("nop_req", 32'(mem_req), 32'd0);
        chk("nop_done", 32'(done_valid), 32'd1);
        chk("nop_fault", 32'(done_fault), 32'd0);
        chk("nop_daddr", done_addr, 32'h30);
        step();
        mem_ack = 1'b0;
        chk("nop_idle", 32'(in_ready), 32'd1);
        chk("nop_req2", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
